// File: rtl/seq_tx_if.sv
// ============================================================================
// Module   : seq_tx_if
// Purpose  : Frame-request and serial-output bundle for seq_tx.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              x;
  logic              valid;
  logic              done;

  modport master (
    output start,
    output data,
    input  ready,
    input  x,
    input  valid,
    input  done
  );

  modport slave (
    input  start,
    input  data,
    output ready,
    output x,
    output valid,
    output done
  );
endinterface

`default_nettype wire

// File: rtl/seq_tx.sv
// ============================================================================
// Module   : seq_tx
// Purpose  : Serialises preamble, payload (MSB first) and optional even parity.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_tx #(
  parameter int               DATA_W    = 8,
  parameter int               PRE_W     = 3,
  parameter logic [PRE_W-1:0] PREAMBLE  = 3'b101,
  parameter int               PARITY_EN = 1
) (
  input  logic   clock,
  input  logic   reset,
  seq_tx_if.slave bus
);

  localparam int c_max   = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int CNT_W   = (c_max > 1) ? $clog2(c_max) : 1;
  localparam int c_ext_w = 2 ** CNT_W;
  // Preamble widened so the counter can index it without a width mismatch.
  localparam logic [c_ext_w-1:0] c_pre_ext = c_ext_w'(PREAMBLE);
  localparam logic c_done_after_pre = (DATA_W == 1) && (PARITY_EN == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_PAR  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic              r_par;
  logic              r_x;
  logic              r_valid;
  logic              r_done;

  logic [DATA_W-1:0] w_shl;
  logic [CNT_W-1:0]  w_cnt_dec;

  assign w_shl     = r_shreg << 1;
  assign w_cnt_dec = r_cnt - CNT_W'(1);

  assign bus.ready = (r_state == S_IDLE);
  assign bus.x     = r_x;
  assign bus.valid = r_valid;
  assign bus.done  = r_done;

  // Outputs are loaded with the value belonging to the state being entered,
  // so x/valid/done are flops yet line up exactly with r_state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_par   <= 1'b0;
      r_x     <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_PRE;
            r_cnt   <= CNT_W'(PRE_W - 1);
            r_shreg <= bus.data;
            r_par   <= ^bus.data;
            r_x     <= PREAMBLE[PRE_W-1];
            r_valid <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_x     <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
          end
        end

        S_PRE: begin
          if (r_cnt == '0) begin
            r_state <= S_DATA;
            r_cnt   <= CNT_W'(DATA_W - 1);
            r_x     <= r_shreg[DATA_W-1];
            r_done  <= c_done_after_pre;
          end else begin
            r_cnt   <= w_cnt_dec;
            r_x     <= c_pre_ext[w_cnt_dec];
          end
          r_valid <= 1'b1;
        end

        S_DATA: begin
          if (r_cnt == '0) begin
            if (PARITY_EN != 0) begin
              r_state <= S_PAR;
              r_x     <= r_par;
              r_valid <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_x     <= 1'b0;
              r_valid <= 1'b0;
              r_done  <= 1'b0;
            end
          end else begin
            r_cnt   <= w_cnt_dec;
            r_shreg <= w_shl;
            r_x     <= w_shl[DATA_W-1];
            r_valid <= 1'b1;
            r_done  <= (PARITY_EN == 0) && (r_cnt == CNT_W'(1));
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_x     <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_tx.sv
// ============================================================================
// Module   : tb_seq_tx
// Purpose  : Directed-vector bench for seq_tx, with and without parity.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_tx;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  seq_tx_if #(.DATA_W(8)) if_a ();
  seq_tx_if #(.DATA_W(8)) if_b ();

  seq_tx #(
    .DATA_W    (8),
    .PRE_W     (3),
    .PREAMBLE  (3'b101),
    .PARITY_EN (1)
  ) u_dut_par (
    .clock (clock),
    .reset (reset),
    .bus   (if_a.slave)
  );

  seq_tx #(
    .DATA_W    (8),
    .PRE_W     (3),
    .PREAMBLE  (3'b101),
    .PARITY_EN (0)
  ) u_dut_nopar (
    .clock (clock),
    .reset (reset),
    .bus   (if_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // {x, valid, done, ready} of the selected instance
  function automatic logic [3:0] obs_of(input bit sel);
    if (sel) return {if_b.x, if_b.valid, if_b.done, if_b.ready};
    else     return {if_a.x, if_a.valid, if_a.done, if_a.ready};
  endfunction

  task automatic drive(input bit sel, input logic st, input logic [7:0] d);
    if (sel) begin if_b.start = st; if_b.data = d; end
    else     begin if_a.start = st; if_a.data = d; end
  endtask

  // Called just after the accepting edge; walks the n frame bits, then the idle cycle.
  // poke >= 0 pulses start with data 3C in that bit slot; hold keeps start high.
  task automatic check_frame(input bit sel, input int n, input logic [11:0] exp,
                             input int poke, input bit hold, input string tag);
    for (int i = 0; i < n; i++) begin
      if (!hold) drive(sel, (i == poke), (i == poke) ? 8'h3C : 8'h00);
      check($sformatf("%s bit%0d", tag, i), {28'd0, obs_of(sel)},
            {28'd0, exp[n-1-i], 1'b1, (i == n-1), 1'b0});
      tick();
    end
    check($sformatf("%s idle", tag), {28'd0, obs_of(sel)}, 32'b0001);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    #12;
    check("reset a", {28'd0, obs_of(1'b0)}, 32'b0001);
    check("reset b", {28'd0, obs_of(1'b1)}, 32'b0001);
    #3 reset = 1'b1;
    tick();
    check("post reset idle", {28'd0, obs_of(1'b0)}, 32'b0001);

    // A5 with parity: 101 10100101 0
    drive(1'b0, 1'b1, 8'hA5);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    check_frame(1'b0, 12, 12'b101_10100101_0, -1, 1'b0, "a5");

    drive(1'b0, 1'b1, 8'h01);
    tick();
    check_frame(1'b0, 12, 12'b101_00000001_1, -1, 1'b0, "h01");

    drive(1'b0, 1'b1, 8'h00);
    tick();
    check_frame(1'b0, 12, 12'b101_00000000_0, -1, 1'b0, "h00");

    // No parity, FF: 101 11111111
    drive(1'b1, 1'b1, 8'hFF);
    tick();
    check_frame(1'b1, 11, 12'b0_101_11111111, -1, 1'b0, "nopar ff");

    // Start pulsed mid-frame with different data must be ignored
    drive(1'b0, 1'b1, 8'hA5);
    tick();
    drive(1'b0, 1'b0, 8'h3C);
    check_frame(1'b0, 12, 12'b101_10100101_0, 4, 1'b0, "ignore");
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("no queued frame %0d", i), {28'd0, obs_of(1'b0)}, 32'b0001);
    end

    // Start held across two frames; data changes right after acceptance
    drive(1'b0, 1'b1, 8'h0F);
    tick();
    drive(1'b0, 1'b1, 8'hF0);
    check_frame(1'b0, 12, 12'b101_00001111_0, -1, 1'b1, "held1");
    tick();
    drive(1'b0, 1'b0, 8'h00);
    check_frame(1'b0, 12, 12'b101_11110000_0, -1, 1'b1, "held2");

    // Asynchronous reset in the middle of DATA
    tick();
    drive(1'b0, 1'b1, 8'hA5);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    check("mid data valid", {31'd0, if_a.valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async reset", {28'd0, obs_of(1'b0)}, 32'b0001);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("held reset %0d", i), {28'd0, obs_of(1'b0)}, 32'b0001);
    end
    #2 reset = 1'b1;
    tick();
    check("no resume", {28'd0, obs_of(1'b0)}, 32'b0001);
    drive(1'b0, 1'b1, 8'h3C);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    check_frame(1'b0, 12, 12'b101_00111100_0, -1, 1'b0, "after reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
